// File: rtl/cla_pkg.sv
// Shared types and helpers for the arbiter around the 20-bit pipelined CLA.
package cla_pkg;

    localparam int unsigned CLA_W    = 20;
    localparam int unsigned CLA_LAT  = 7;
    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } cla_tag_t;

    typedef struct packed {
        logic                found;
        logic [TAG_ID_W-1:0] idx;
    } rr_pick_t;

    // Bits of eligible at or above the real requester count must be zero, so wrapping at
    // MAX_REQ yields the same order as wrapping at the requester count.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  eligible,
                                         input logic [TAG_ID_W-1:0] last);
        rr_pick_t            res;
        logic [TAG_ID_W-1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = last + TAG_ID_W'(k);
            if (!res.found && eligible[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cla_tag_pipe.sv
// Fixed-depth shift register with asynchronous clear; the MSB of each stage is its valid flag.
module cla_tag_pipe #(
    parameter int unsigned Depth = 7,
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic [Depth-1:0] flags
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[Depth-1];

    always_comb begin
        flags = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            flags[i] = stage_q[i][Width-1];
        end
    end

endmodule

// File: rtl/cla_pipe_arbiter.sv
// Round-robin issue of requester operations into a shared fixed-latency adder, with a tag
// pipeline that routes each result back and per-requester outstanding limits.
module cla_pipe_arbiter
    import cla_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LAT     = CLA_LAT,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*CLA_W-1:0]     req_a,
    input  logic [NREQ*CLA_W-1:0]     req_b,
    input  logic [NREQ-1:0]           req_cin,
    output logic [NREQ-1:0]           req_ready,
    output logic [CLA_W-1:0]          add_a,
    output logic [CLA_W-1:0]          add_b,
    output logic                      add_cin,
    input  logic [CLA_W-1:0]          add_s,
    input  logic                      add_cout,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [CLA_W-1:0]          rsp_s,
    output logic                      rsp_cout,
    output logic                      busy
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    logic [CntW-1:0]    cnt_q [NREQ];
    logic [CntW-1:0]    cnt_d [NREQ];
    logic [IdW-1:0]     last_q;
    logic [NREQ-1:0]    retire_hit;
    logic [NREQ-1:0]    eligible;
    logic [MAX_REQ-1:0] elig_ext;
    rr_pick_t           pick;
    logic               grant_valid;
    logic [IdW-1:0]     grant_id;
    cla_tag_t           tag_in;
    cla_tag_t           tag_out;
    logic [LAT-1:0]     tag_flags;

    // A retiring requester regains its credit in the same cycle it retires.
    always_comb begin
        retire_hit = '0;
        eligible   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            retire_hit[i] = tag_out.valid && (tag_out.id[IdW-1:0] == IdW'(i));
            eligible[i]   = req_valid[i] && ((cnt_q[i] < CntW'(MAX_OUT)) || retire_hit[i]);
        end
        elig_ext    = MAX_REQ'(eligible);
        pick        = rr_pick(elig_ext, TAG_ID_W'(last_q));
        grant_valid = pick.found && rst_n;
        grant_id    = pick.idx[IdW-1:0];
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_valid && (grant_id == IdW'(i))) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*CLA_W +: CLA_W];
                add_b        = req_b[i*CLA_W +: CLA_W];
                add_cin      = req_cin[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({req_ready[i], retire_hit[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IdW'(NREQ - 1);
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (grant_valid) begin
                last_q <= grant_id;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = grant_valid;
        tag_in.id    = grant_valid ? TAG_ID_W'(grant_id) : '0;
    end

    cla_tag_pipe #(
        .Depth(LAT),
        .Width($bits(cla_tag_t))
    ) u_tag_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (tag_in),
        .dout (tag_out),
        .flags(tag_flags)
    );

    // The adder holds no validity; its outputs are only forwarded under a live tag.
    assign rsp_valid = tag_out.valid;
    assign rsp_id    = tag_out.id[IdW-1:0];
    assign rsp_s     = rsp_valid ? add_s : '0;
    assign rsp_cout  = rsp_valid ? add_cout : 1'b0;
    assign busy      = |tag_flags;

    if (IdW < TAG_ID_W) begin : g_unused_id
        logic unused_id_bits;
        assign unused_id_bits = ^{pick.idx[TAG_ID_W-1:IdW], tag_out.id[TAG_ID_W-1:IdW]};
    end

endmodule

// File: tb/tb_cla_pipe_arbiter.sv
// Bench for cla_pipe_arbiter: behavioural adder, transaction-level reference model, scenarios.
module tb_cla_pipe_arbiter;

    localparam int NREQ    = 4;
    localparam int LAT     = 7;
    localparam int MAX_OUT = 3;
    localparam int W       = 20;
    localparam int VW      = NREQ + 1 + 2 + W + 1 + 1 + W + W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_a, add_b, add_s;
    logic              add_cin, add_cout;
    logic              rsp_valid, rsp_cout, busy;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_s;

    int checks = 0;
    int errors = 0;

    cla_pipe_arbiter #(
        .NREQ   (NREQ),
        .LAT    (LAT),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .req_ready(req_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_s    (rsp_s),
        .rsp_cout (rsp_cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // External adder: LAT-edge pipeline, no reset; contents are scrambled while reset is held.
    logic [W:0] adder_in;
    logic [W:0] adder_pipe [LAT];
    always @(negedge clk) adder_in <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) adder_pipe[i] <= (W+1)'($urandom());
        end else begin
            adder_pipe[0] <= adder_in;
            for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
        end
    end
    assign add_s    = adder_pipe[LAT-1][W-1:0];
    assign add_cout = adder_pipe[LAT-1][W];

    // Reference model: credit counts, last winner, in-flight operations with due cycles.
    typedef struct {
        int         id;
        logic [W:0] res;
        int         due;
    } op_t;

    op_t             infl [$];
    int              m_cnt [NREQ];
    int              m_last;
    int              cyc = 0;
    int              e_gnt;
    logic [NREQ-1:0] e_ready;
    logic            e_rsp_valid, e_rsp_cout, e_busy, e_add_cin;
    logic [1:0]      e_rsp_id;
    logic [W-1:0]    e_rsp_s, e_add_a, e_add_b;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_last = NREQ - 1;
        infl.delete();
    endtask

    task automatic model_eval();
        e_rsp_valid = 1'b0;
        e_rsp_id    = '0;
        e_rsp_s     = '0;
        e_rsp_cout  = 1'b0;
        if (infl.size() > 0 && infl[0].due == cyc) begin
            e_rsp_valid = 1'b1;
            e_rsp_id    = 2'(infl[0].id);
            e_rsp_s     = infl[0].res[W-1:0];
            e_rsp_cout  = infl[0].res[W];
        end
        e_busy = (infl.size() > 0);
        e_gnt  = -1;
        if (rst_n) begin
            for (int j = 1; j <= NREQ; j++) begin
                int idx;
                idx = (m_last + j) % NREQ;
                if (e_gnt < 0 && req_valid[idx] &&
                    (m_cnt[idx] < MAX_OUT || (e_rsp_valid && int'(e_rsp_id) == idx)))
                    e_gnt = idx;
            end
        end
        e_ready   = '0;
        e_add_a   = '0;
        e_add_b   = '0;
        e_add_cin = 1'b0;
        if (e_gnt >= 0) begin
            e_ready[e_gnt] = 1'b1;
            e_add_a        = req_a[e_gnt*W +: W];
            e_add_b        = req_b[e_gnt*W +: W];
            e_add_cin      = req_cin[e_gnt];
        end
    endtask

    task automatic model_advance();
        if (e_rsp_valid) begin
            void'(infl.pop_front());
            m_cnt[e_rsp_id]--;
        end
        if (e_gnt >= 0) begin
            m_cnt[e_gnt]++;
            m_last = e_gnt;
            infl.push_back('{id: e_gnt,
                             res: {1'b0, e_add_a} + {1'b0, e_add_b} + {{W{1'b0}}, e_add_cin},
                             due: cyc + LAT - 1});
        end
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, busy, add_a, add_b, add_cin};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_ready, e_rsp_valid, e_rsp_id, e_rsp_s, e_rsp_cout, e_busy,
                e_add_a, e_add_b, e_add_cin};
    endfunction

    task automatic sample();
        @(negedge clk);
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_advance();
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'($urandom());
            req_b[i*W +: W] = W'($urandom());
            req_cin[i]      = 1'($urandom());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int n);
        req_valid = '0;
        for (int c = 0; c < n; c++) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s_drain cyc=%0d got=%h exp=%h", name, cyc, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        req_valid = '1;
        rand_ops();
        sample();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", obs_vec());
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single_issue();
        int issue_cyc, seen, lat;
        logic [W-1:0] s_seen;
        logic         c_seen;
        logic [1:0]   id_seen;
        seen = 0; lat = -1; s_seen = '0; c_seen = 1'b0; id_seen = '0;
        req_valid = 4'b0001;
        req_a[0 +: W] = 20'h06F77;
        req_b[0 +: W] = 20'h07178;
        req_cin[0]    = 1'b0;
        sample();
        issue_cyc = cyc;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        for (int c = 0; c < LAT + 4; c++) begin
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (rsp_valid === 1'b1) begin
                seen++;
                lat = cyc - issue_cyc;
                s_seen = rsp_s; c_seen = rsp_cout; id_seen = rsp_id;
            end
            tick();
        end
        checks++;
        if (seen != 1 || lat != LAT) begin
            errors++;
            $display("FAIL single_latency got=%0d (count %0d) exp=%0d", lat, seen, LAT);
        end
        checks++;
        if ({id_seen, s_seen, c_seen} !== {2'd0, 20'h0E0EF, 1'b0}) begin
            errors++;
            $display("FAIL single_result got id=%0d s=%h c=%b exp id=0 s=0e0ef c=0",
                     id_seen, s_seen, c_seen);
        end
    endtask

    task automatic test_round_robin();
        int ids [$];
        logic [NREQ-1:0] want;
        do_reset();
        for (int c = 0; c < 8 + LAT + 4; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            rand_ops();
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (c < 8) begin
                want = 4'(1 << (c % 4));
                checks++;
                if (req_ready !== want) begin
                    errors++;
                    $display("FAIL rr_grant step=%0d got=%b exp=%b", c, req_ready, want);
                end
            end
            if (rsp_valid === 1'b1) ids.push_back(int'(rsp_id));
            tick();
        end
        checks++;
        if (ids.size() != 8) begin
            errors++;
            $display("FAIL rr_rsp_count got=%0d exp=8", ids.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (ids[i] != i % 4) begin
                    errors++;
                    $display("FAIL rr_rsp_order idx=%0d got=%0d exp=%0d", i, ids[i], i % 4);
                end
            end
        end
    endtask

    task automatic test_credit_limit();
        logic [11:0] rdy_hist, rsp_hist;
        rdy_hist = '0; rsp_hist = '0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'b0100;
            rand_ops();
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL credit_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            rdy_hist[c] = req_ready[2];
            rsp_hist[c] = rsp_valid;
            tick();
        end
        checks++;
        if (rdy_hist !== 12'h387) begin
            errors++;
            $display("FAIL credit_ready_pattern got=%h exp=387", rdy_hist);
        end
        checks++;
        if (rsp_hist[7] !== 1'b1) begin
            errors++;
            $display("FAIL credit_retire_cycle got=%b exp=1", rsp_hist[7]);
        end
        drain("credit", LAT + 4);
    endtask

    task automatic test_carry_out();
        int hits = 0;
        req_valid = 4'b1000;
        req_a[3*W +: W] = 20'hFFFFF;
        req_b[3*W +: W] = 20'h00001;
        req_cin[3]      = 1'b0;
        sample();
        tick();
        req_valid = 4'b0010;
        req_a[1*W +: W] = 20'h00001;
        req_b[1*W +: W] = 20'h00603;
        req_cin[1]      = 1'b1;
        sample();
        tick();
        req_valid = '0;
        for (int c = 0; c < LAT + 4; c++) begin
            sample();
            if (rsp_valid === 1'b1 && rsp_id == 2'd3) begin
                hits++;
                checks++;
                if ({rsp_s, rsp_cout} !== {20'h00000, 1'b1}) begin
                    errors++;
                    $display("FAIL carry_full got s=%h c=%b exp s=00000 c=1", rsp_s, rsp_cout);
                end
            end else if (rsp_valid === 1'b1 && rsp_id == 2'd1) begin
                hits++;
                checks++;
                if ({rsp_s, rsp_cout} !== {20'h00605, 1'b0}) begin
                    errors++;
                    $display("FAIL carry_cin got s=%h c=%b exp s=00605 c=0", rsp_s, rsp_cout);
                end
            end
            tick();
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("FAIL carry_rsp_count got=%0d exp=2", hits);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0001;
            rand_ops();
            sample();
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        req_valid = '0;
        sample();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h exp=0", obs_vec());
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            sample();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cyc=%0d got v=%b busy=%b exp v=0 busy=0",
                         cyc, rsp_valid, busy);
            end
            tick();
        end
        req_valid = 4'hF;
        rand_ops();
        sample();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_first_grant got=%b exp=0001", req_ready);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            req_valid = 4'b0001;
            rand_ops();
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            tick();
        end
        drain("midreset", LAT + 3);
    endtask

    task automatic test_issue_retire();
        logic [NREQ-1:0] want [14] = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h8, 4'h0,
                                       4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h8, 4'h0};
        int sim = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            req_valid = 4'b1010;
            rand_ops();
            sample();
            checks++;
            if (req_ready !== want[c]) begin
                errors++;
                $display("FAIL ir_grant step=%0d got=%b exp=%b", c, req_ready, want[c]);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ir_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (req_ready[1] === 1'b1 && rsp_valid === 1'b1 && rsp_id == 2'd1) sim++;
            tick();
        end
        checks++;
        if (sim != 3) begin
            errors++;
            $display("FAIL ir_same_cycle_count got=%0d exp=3", sim);
        end
        drain("ir", LAT + 3);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom());
            rand_ops();
            sample();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            tick();
        end
        drain("random", LAT + 3);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_issue();
        test_round_robin();
        test_credit_limit();
        test_carry_out();
        test_reset_midflight();
        test_issue_retire();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_arbiter.md
# cla_pipe_arbiter

Round-robin arbiter and in-flight scheduler that shares one 20-bit pipelined carry-lookahead adder (`Pip20CLA`, fixed 7-cycle latency) among `NREQ` requesters. It issues at most one operation per cycle into the adder and tracks each operation with a tag pipeline that matches the adder latency. It routes each sum and carry-out back to the issuing requester and enforces a per-requester outstanding-operation limit. It sits between the requester blocks and an externally instantiated `Pip20CLA`, which has no reset; this block supplies all validity state.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, ≥2.
- `LAT`, default 7: adder latency in clk edges, from operands applied to `s`/`cout` valid.
- `MAX_OUT`, default 3: maximum in-flight operations per requester, 1..LAT.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: request present, one bit per requester.
- `req_a`, `req_b`  in  NREQ×20: operands, packed; requester i occupies bits [20i+19:20i].
- `req_cin`  in  NREQ: carry-in per requester.
- `req_ready`  out  NREQ: one-hot or zero; operation accepted this cycle.
- `add_a`, `add_b`  out  20: to adder operands.
- `add_cin`  out  1: to adder carry-in.
- `add_s`  in  20: adder sum.
- `add_cout`  in  1: adder carry-out.
- `rsp_valid`  out  1: result available this cycle; no backpressure.
- `rsp_id`  out  clog2(NREQ): requester that owns the result.
- `rsp_s`  out  20, `rsp_cout`  out  1: result.
- `busy`  out  1: any operation in flight.

## Operation

- **Eligibility:** requester i is eligible when `req_valid[i]` and `outstanding[i] < MAX_OUT`.
- **Grant:** round-robin grant among eligible requesters, searching from `last+1` with wrap NREQ-1→0.
  - `req_ready[grant]`=1 combinationally in the same cycle; the handshake completes when valid and ready are both 1.
  - On a grant, `last` updates to the granted index.
- **Adder drive:** `add_a`/`add_b`/`add_cin` are combinational muxes of the granted requester's operands; they are all-zero when nothing is granted.
- **Tag pipe:** a shift register of depth LAT holding {valid, id}. Stage 0 loads {handshake, grant id} every cycle; the stage LAT-1 output drives `rsp_valid`/`rsp_id`.
  - `rsp_s`/`rsp_cout` pass `add_s`/`add_cout` through unregistered.
  - `rsp_s`/`rsp_cout` are zero when `rsp_valid`=0.
- **Outstanding counters:** one per requester, width clog2(MAX_OUT+1). Increment on issue, decrement on retire.
  - Simultaneous issue and retire for the same id leaves the counter unchanged.
- **`busy`:** OR of the tag-valid bits.

## Timing

- Issue at edge k (handshake sampled) → `rsp_valid` high in the cycle after edge k+LAT-1, i.e. aligned with `add_s` for those operands.
  - Throughput is 1 operation per cycle.
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0, `busy`=0.
  - All tags invalid, all counters 0, `last`=NREQ-1, so requester 0 wins first.
- **Reset mid-operation:** all in-flight tags are dropped. Adder pipeline contents become don't-care, and no stale `rsp_valid` ever appears after deassertion.
- **Full:** a requester at MAX_OUT is skipped by arbitration; others proceed. It becomes eligible in the same cycle its retire occurs, because the counter compare uses the pre-decrement value minus the retire.
- **Single requester:** that requester issues every cycle until MAX_OUT is reached, then stalls until a retire.
- **Requester dropping valid without handshake:** no state change.

## Structure

- **Shared package `cla_pkg`:**
  - `CLA_W`=20, `CLA_LAT`=7.
  - Typedef for the tag struct {valid, id}.
  - Function `rr_pick(eligible, last)`.
- **Sub-module `cla_tag_pipe`:** parameterised depth/width shift register with async active-low clear, instantiated once for the tag path.
- The adder itself is not instantiated here; the top level connects this block to `Pip20CLA`.

## Test plan

- **Single issue:** requester 0 issues a=0x06F77, b=0x07178, cin=0 at cycle 1 → `rsp_valid` with `rsp_id`=0, `rsp_s`=0x0E0EF, `rsp_cout`=0 exactly LAT cycles later; `busy` is high throughout.
- **Round-robin:** all four requesters hold valid for 8 cycles → grants 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle.
- **Credit limit:** only requester 2 is valid, MAX_OUT=3 → 3 back-to-back issues, `req_ready[2]`=0 for 4 cycles, then re-issue in the cycle of the first retire.
- **Carry-out:** a=0xFFFFF, b=0x00001, cin=0 → `rsp_s`=0x00000, `rsp_cout`=1. Also a=0x00001, b=0x00603, cin=1 → `rsp_s`=0x00605.
- **Reset mid-flight:** issue 3 operations, assert `rst_n` low for 1 cycle at cycle 3 → no `rsp_valid` for the following LAT cycles, counters 0, and the next grant goes to requester 0.
- **Simultaneous issue and retire:** requester 1 issues on the same edge one of its operations retires → counter unchanged; checked by a scoreboard comparing every response against a+b+cin.
